// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer that owns the HI/LO registers.
// Latency: MULT/MULTU take MULT_CYCLES and DIV/DIVU take DIV_CYCLES busy cycles. MTHI and MTLO complete on the issue edge.
// Backpressure: there is no queue. md_stall holds issue upstream, and a start that arrives while busy is dropped.
//
// Ports:
//   clk, reset (async, active-low)
//   start/op/src_a/src_b : command issue from EX
//   hi, lo               : architectural HI/LO registers
//   busy, done           : operation in flight / one-cycle result pulse
//   md_stall             : combinational stall request to the hazard unit
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        md_stall
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, nextState;
  logic [3:0]  cnt;
  logic [31:0] resHi, resLo;
  logic        resWrite;   // cleared on divide-by-zero so HI/LO are left untouched

  logic        isMulDiv;
  logic [63:0] mulA, mulB, product;
  logic        negA, negB;
  logic [31:0] magA, magB, magQ, magR, quo, rem;

  assign isMulDiv = (op <= 3'd3);
  assign busy     = (state == RUN);
  assign md_stall = busy | (start & isMulDiv);

  // Sign/zero extend to 64 bits. The low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  always_comb begin
    mulA = {32'd0, src_a};
    mulB = {32'd0, src_b};
    if (!op[0]) begin
      mulA = {{32{src_a[31]}}, src_a};
      mulB = {{32{src_b[31]}}, src_b};
    end
    product = mulA * mulB;
  end

  // Signed division is done on magnitudes and the signs are fixed up afterwards.
  // The quotient is negated when the operand signs differ. The remainder follows the dividend.
  // For 0x80000000 / -1 the magnitude quotient 0x80000000 passes through unchanged.
  always_comb begin
    negA = ~op[0] & src_a[31];
    negB = ~op[0] & src_b[31];
    magA = negA ? (32'd0 - src_a) : src_a;
    magB = negB ? (32'd0 - src_b) : src_b;
    magQ = magA / magB;
    magR = magA % magB;
    quo  = (negA ^ negB) ? (32'd0 - magQ) : magQ;
    rem  = negA ? (32'd0 - magR) : magR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start && isMulDiv) nextState = RUN;
      RUN:     if (cnt == 4'd1) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
      cnt      <= 4'd0;
      resHi    <= 32'd0;
      resLo    <= 32'd0;
      resWrite <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              {resHi, resLo} <= product;
              resWrite       <= 1'b1;
              cnt            <= 4'(MULT_CYCLES);
            end
            3'd2, 3'd3: begin
              resHi    <= rem;
              resLo    <= quo;
              resWrite <= (src_b != 32'd0);
              cnt      <= 4'(DIV_CYCLES);
            end
            3'd4:    hi <= src_a;
            3'd5:    lo <= src_a;
            default: ;
          endcase
        end
      end else begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (resWrite) begin
            hi <= resHi;
            lo <= resLo;
          end
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk, reset, start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic [31:0] hi, lo;
  logic        busy, done, md_stall;

  mdu_sequencer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .md_stall(md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
  endtask

  // Reference model. An operation accepted at edge number c finishes at edge c+N.
  // Busy is expected after edge e while e < finishEdge.
  longint          cyc        = 0;
  longint          finishEdge = -1;
  logic [31:0]     mHi = 0, mLo = 0, pHi = 0, pLo = 0;
  bit              pWr = 0, mDone = 0, accepted = 0;
  int              hazardStarts = 0;
  longint          sa, sb, sq, sr;
  longint unsigned ua, ub, uq, ur;
  logic [63:0]     prod;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mHi = 0; mLo = 0; finishEdge = -1; mDone = 0; accepted = 0;
    end else begin
      cyc++;
      mDone = (cyc == finishEdge);
      if (mDone && pWr) begin mHi = pHi; mLo = pLo; end
      accepted = 0;
      if (start) begin
        if (cyc <= finishEdge) hazardStarts++;
        else begin
          accepted = 1;
          sa = longint'($signed(src_a)); sb = longint'($signed(src_b));
          ua = {32'd0, src_a};           ub = {32'd0, src_b};
          case (op)
            3'd0: begin prod = sa * sb; {pHi, pLo} = prod; pWr = 1; finishEdge = cyc + MULT_CYCLES; end
            3'd1: begin prod = ua * ub; {pHi, pLo} = prod; pWr = 1; finishEdge = cyc + MULT_CYCLES; end
            3'd2: begin
              pWr = (src_b != 0);
              if (pWr) begin sq = sa / sb; sr = sa % sb; pLo = sq[31:0]; pHi = sr[31:0]; end
              finishEdge = cyc + DIV_CYCLES;
            end
            3'd3: begin
              pWr = (src_b != 0);
              if (pWr) begin uq = ua / ub; ur = ua % ub; pLo = uq[31:0]; pHi = ur[31:0]; end
              finishEdge = cyc + DIV_CYCLES;
            end
            3'd4: mHi = src_a;
            3'd5: mLo = src_a;
            default: ;
          endcase
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("hi", hi, mHi);
    chk("lo", lo, mLo);
    chk("busy", {31'd0, busy}, {31'd0, cyc < finishEdge});
    chk("done", {31'd0, done}, {31'd0, mDone});
    chk("md_stall", {31'd0, md_stall}, {31'd0, (cyc < finishEdge) || (start && op <= 3'd3)});
  end

  // Each task starts and ends 2 time units after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int tries;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tries = 0;
    do begin
      @(posedge clk); #2;
      tries++;
    end while (hold && !accepted && tries < 30);
    if (hold && !accepted) chk("issue_accept_timeout", 32'd0, 32'd1);
    start = 1'b0; op = 3'd6;
  endtask

  task automatic runFor(input int n, output int nb, output int nd);
    nb = 0; nd = 0;
    repeat (n) begin
      nb += int'(busy); nd += int'(done);
      @(posedge clk); #2;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  int nb, nd;
  logic [2:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd6; src_a = 0; src_b = 0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #2;

    // An asynchronous reset in the third DIV cycle clears everything, and done never pulses.
    issue(3'd4, 32'h0000_AAAA, 0, 1);
    issue(3'd5, 32'h0000_BBBB, 0, 1);
    issue(3'd2, 32'd100, 32'd7, 1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    runFor(12, nb, nd);
    chk("abort_no_done", nd, 32'd0);
    chk("abort_no_busy", nb, 32'd0);

    // MULT -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1);
    runFor(14, nb, nd);
    chk("mult_busy_cycles", nb, 32'd5);
    chk("mult_done_pulses", nd, 32'd1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU max * max
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    runFor(8, nb, nd);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1);
    runFor(14, nb, nd);
    chk("div_busy_cycles", nb, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // MTHI/MTLO, then DIVU by zero leaves HI/LO alone but still pulses done.
    issue(3'd5, 32'h0000_5678, 0, 1);
    issue(3'd4, 32'h0000_1234, 0, 1);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd3, 32'd77, 32'd0, 1);
    runFor(14, nb, nd);
    chk("div0_busy_cycles", nb, 32'd10);
    chk("div0_done_pulses", nd, 32'd1);
    chk("div0_hi", hi, 32'h0000_1234);
    chk("div0_lo", lo, 32'h0000_5678);

    // Overflow case of signed division.
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    runFor(12, nb, nd);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0000_0000);

    // A MULT pulsed while a DIV is in flight is dropped. The DIV result lands on schedule.
    issue(3'd2, 32'd1000, 32'hFFFF_FFFD, 0);
    runFor(3, nb, nd);
    issue(3'd0, 32'd7, 32'd9, 0);
    runFor(12, nb, nd);
    chk("ignored_done_pulses", nd, 32'd1);
    chk("ignored_lo", lo, 32'hFFFF_FEB3);
    chk("ignored_hi", hi, 32'h0000_0001);
    chk("ignored_idle", {31'd0, busy}, 32'd0);
    $display("note: %0d start(s) issued while busy were dropped (hazard violation)", hazardStarts);

    // Randomized traffic. Issue is held while stalled, so back-to-back issue is exercised.
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      if (rop >= 3'd2 && rop <= 3'd3 && $urandom_range(0, 5) == 0) rb = 32'd0;
      issue(rop, ra, rb, 1);
      repeat ($urandom_range(0, 12)) begin @(posedge clk); #2; end
    end
    runFor(16, nb, nd);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
